// File: rtl/mdu.sv
// Multiply/divide unit beside EX: multi-cycle MULT/DIV into architectural HI/LO,
// with MTHI/MTLO writes and a busy/stall indication for the hazard logic.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] v1,
  input  logic [31:0] v2,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, stateNext;
  logic [3:0]  count;
  logic [31:0] pendHi, pendLo;
  logic        pendValid;

  logic        accept, commit, writeHi, writeLo;
  logic [63:0] mulS, mulU;
  logic [31:0] absA, absB, divisor, quoU, remU, quoS, remS;
  logic        isDiv;

  assign busy      = (state == RUN);
  assign stall_req = busy | (start & ~op[2]);
  assign isDiv     = (op == 3'd2) || (op == 3'd3);

  // Signed divide works on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    mulS    = $signed({{32{v1[31]}}, v1}) * $signed({{32{v2[31]}}, v2});
    mulU    = {32'b0, v1} * {32'b0, v2};
    absA    = (op == 3'd2 && v1[31]) ? (~v1 + 32'd1) : v1;
    absB    = (op == 3'd2 && v2[31]) ? (~v2 + 32'd1) : v2;
    divisor = (absB == '0) ? 32'd1 : absB;
    quoU    = absA / divisor;
    remU    = absA % divisor;
    quoS    = (v1[31] ^ v2[31]) ? (~quoU + 32'd1) : quoU;
    remS    = v1[31] ? (~remU + 32'd1) : remU;
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    commit    = 1'b0;
    writeHi   = 1'b0;
    writeLo   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (~op[2]) begin
            accept    = 1'b1;
            stateNext = RUN;
          end
          writeHi = (op == 3'd4);
          writeLo = (op == 3'd5);
        end
      end
      RUN: begin
        if (count == 4'd1) begin
          commit    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      pendHi    <= '0;
      pendLo    <= '0;
      pendValid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        count     <= isDiv ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        pendValid <= !(isDiv && v2 == '0);
        case (op)
          3'd0:    {pendHi, pendLo} <= mulS;
          3'd1:    {pendHi, pendLo} <= mulU;
          3'd2:    {pendHi, pendLo} <= {remS, quoS};
          default: {pendHi, pendLo} <= {remU, quoU};
        endcase
      end else if (state == RUN) begin
        count <= count - 4'd1;
      end
      if (commit && pendValid) begin
        hi <= pendHi;
        lo <= pendLo;
      end
      if (writeHi) hi <= v1;
      if (writeLo) lo <= v1;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: expected HI/LO pairs queued at issue, checked at commit.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] v1, v2;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int unsigned vectors = 0;
  int unsigned fails   = 0;
  logic [63:0] sb[$];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .v1(v1), .v2(v2),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; issues the request, counts busy cycles, checks commit.
  task automatic doOp(input string tag, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] exp, input int n,
                      input bit inject);
    int cnt = 0;
    bit stallOk = 1'b1;
    logic [63:0] e;
    start = 1'b1; op = o; v1 = a; v2 = b;
    sb.push_back(exp);
    #1 check({tag, " stall_req at request"}, {63'b0, stall_req}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      if (!stall_req) stallOk = 1'b0;
      cnt++;
      start = 1'b0;
      if (inject && cnt == 2) begin start = 1'b1; op = 3'd5; v1 = 32'hDEADBEEF; end
      if (inject && cnt == 3) begin start = 1'b1; op = 3'd3; v1 = 32'd9; v2 = 32'd2; end
      if (start) #1 if (!stall_req) stallOk = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " busy cycles"}, 64'(cnt), 64'(n));
    check({tag, " stall_req during busy"}, {63'b0, stallOk}, 64'd1);
    e = sb.pop_front();
    check({tag, " hi:lo"}, {hi, lo}, e);
  endtask

  task automatic mt(input string tag, input logic [2:0] o, input logic [31:0] d,
                    input logic [63:0] exp);
    start = 1'b1; op = o; v1 = d;
    @(negedge clk);
    start = 1'b0;
    check(tag, {hi, lo}, exp);
    check({tag, " busy"}, {63'b0, busy}, 64'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = '0; v1 = '0; v2 = '0;
    #1;
    check("reset hi:lo", {hi, lo}, 64'd0);
    check("reset busy", {63'b0, busy}, 64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    doOp("MULT -3*5",  3'd0, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 5, 1'b0);
    doOp("MULTU",      3'd1, 32'hFFFFFFFD, 32'd5, 64'h00000004_FFFFFFF1, 5, 1'b0);
    doOp("DIVU 100/7", 3'd3, 32'd100, 32'd7,      64'h00000002_0000000E, 10, 1'b0);
    doOp("DIV -7/2",   3'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10, 1'b0);
    doOp("DIV 7/-2",   3'd2, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 10, 1'b0);
    doOp("DIV ovf",    3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 10, 1'b0);

    mt("MTHI", 3'd4, 32'h11111111, 64'h11111111_80000000);
    mt("MTLO", 3'd5, 32'h22222222, 64'h11111111_22222222);
    doOp("DIVU by 0",  3'd3, 32'd55, 32'd0,       64'h11111111_22222222, 10, 1'b0);
    doOp("DIV by 0",   3'd2, 32'hFFFFFF00, 32'd0, 64'h11111111_22222222, 10, 1'b0);

    doOp("MULT inject", 3'd0, 32'd3, 32'd3,       64'h00000000_00000009, 5, 1'b1);

    // Reset dropped mid-divide clears state without a clock edge.
    start = 1'b1; op = 3'd2; v1 = 32'd1000; v2 = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async reset hi:lo", {hi, lo}, 64'd0);
    check("async reset busy", {63'b0, busy}, 64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    doOp("MULT 6*7",   3'd0, 32'd6, 32'd7, 64'd42, 5, 1'b0);

    doOp("MULT 2*3",   3'd0, 32'd2, 32'd3, 64'd6, 5, 1'b0);
    doOp("MULT 4*5 b2b", 3'd0, 32'd4, 32'd5, 64'd20, 5, 1'b0);

    mt("MTLO idle", 3'd5, 32'hCAFEF00D, 64'h00000000_CAFEF00D);
    start = 1'b1; op = 3'd6; v1 = 32'h12345678;
    #1 check("no-op stall_req", {63'b0, stall_req}, 64'd0);
    @(negedge clk); start = 1'b0;
    check("no-op hi:lo", {hi, lo}, 64'h00000000_CAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
